// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the D/E register payload layout.
// T_new/Tuse are 3-bit cycle counts; TUSE_NEVER marks an operand that is never read.
package pipe_pkg;

  localparam int TW = 3;
  localparam logic [TW-1:0] TUSE_NEVER = 3'b111;
  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam logic [TW-1:0] T_ONE = 3'd1;

  typedef struct packed {
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [31:0]   rs_data;
    logic [31:0]   rt_data;
    logic [31:0]   pc;
    logic          valid;
    logic [4:0]    reg_addr;
    logic          reg_w;
    logic [31:0]   reg_data;
    logic [TW-1:0] t_new;
  } e_stage_t;

  // One pipeline step closer to ready, never below zero.
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - T_ONE;
  endfunction

endpackage

// File: rtl/stall_unit.sv
// Load-use hazard detector: stalls D when a source register's producer in E or M
// will not have its result ready by the time D needs it.
module stall_unit
  import pipe_pkg::*;
(
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_valid,
  input  logic [4:0]    e_addr,
  input  logic          e_w,
  input  logic [TW-1:0] e_t_new,
  input  logic [4:0]    m_addr,
  input  logic          m_w,
  input  logic [TW-1:0] m_t_new,
  output logic          stall
);

  logic rs_hazard;
  logic rt_hazard;

  // E and M are ORed: any late producer is enough to stall, no priority.
  function automatic logic src_hazard(input logic [4:0] addr, input logic [TW-1:0] tuse,
                                      input logic [4:0] ea, input logic ew, input logic [TW-1:0] et,
                                      input logic [4:0] ma, input logic mw, input logic [TW-1:0] mt);
    logic hit_e;
    logic hit_m;
    hit_e = (addr == ea) && ew && (tuse < et);
    hit_m = (addr == ma) && mw && (tuse < mt);
    return (addr != ZERO_REG) && (tuse != TUSE_NEVER) && (hit_e || hit_m);
  endfunction

  always_comb begin
    rs_hazard = src_hazard(d_rs, d_tuse_rs, e_addr, e_w, e_t_new, m_addr, m_w, m_t_new);
    rt_hazard = src_hazard(d_rt, d_tuse_rt, e_addr, e_w, e_t_new, m_addr, m_w, m_t_new);
    stall     = d_valid && (rs_hazard || rt_hazard);
  end

endmodule

// File: rtl/d_e_reg.sv
// D/E pipeline register with integrated stall detection; a stall loads a bubble.
// Optional STALL_CNT_EN adds a 32-bit free-running stall-cycle counter output.
module d_e_reg
  import pipe_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    D_rs,
  input  logic [4:0]    D_rt,
  input  logic [31:0]   D_rs_Data,
  input  logic [31:0]   D_rt_Data,
  input  logic [4:0]    D_Reg_Addr,
  input  logic          D_Reg_W,
  input  logic [31:0]   D_Reg_Data,
  input  logic [TW-1:0] D_T_new,
  input  logic [TW-1:0] D_Tuse_rs,
  input  logic [TW-1:0] D_Tuse_rt,
  input  logic [31:0]   D_PC,
  input  logic          D_valid,
  input  logic [4:0]    M_Reg_Addr,
  input  logic          M_Reg_W,
  input  logic [TW-1:0] M_T_new,
  output logic [4:0]    E_rs,
  output logic [4:0]    E_rt,
  output logic [31:0]   E_rs_Data,
  output logic [31:0]   E_rt_Data,
  output logic [31:0]   E_PC,
  output logic          E_valid,
  output logic [4:0]    FWD_E_Reg_Addr,
  output logic          FWD_E_Reg_W,
  output logic [31:0]   FWD_E_Reg_Data,
  output logic [TW-1:0] FWD_E_T_new,
  output logic [TW-1:0] E_T_new_next,
`ifdef STALL_CNT_EN
  output logic [31:0]   stall_cnt,
`endif
  output logic          stall
);

  e_stage_t e_q;
  e_stage_t e_d;

  stall_unit u_stall_unit (
    .d_rs      (D_rs),
    .d_rt      (D_rt),
    .d_tuse_rs (D_Tuse_rs),
    .d_tuse_rt (D_Tuse_rt),
    .d_valid   (D_valid),
    .e_addr    (e_q.reg_addr),
    .e_w       (e_q.reg_w),
    .e_t_new   (e_q.t_new),
    .m_addr    (M_Reg_Addr),
    .m_w       (M_Reg_W),
    .m_t_new   (M_T_new),
    .stall     (stall)
  );

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.rs       = D_rs;
      e_d.rt       = D_rt;
      e_d.rs_data  = D_rs_Data;
      e_d.rt_data  = D_rt_Data;
      e_d.pc       = D_PC;
      e_d.valid    = D_valid;
      e_d.reg_addr = D_Reg_Addr;
      // $0 writes and invalid slots must never be forwarded.
      e_d.reg_w    = D_Reg_W && D_valid && (D_Reg_Addr != ZERO_REG);
      e_d.reg_data = D_Reg_Data;
      e_d.t_new    = D_T_new;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) e_q <= '0;
    else        e_q <= e_d;
  end

  assign E_rs           = e_q.rs;
  assign E_rt           = e_q.rt;
  assign E_rs_Data      = e_q.rs_data;
  assign E_rt_Data      = e_q.rt_data;
  assign E_PC           = e_q.pc;
  assign E_valid        = e_q.valid;
  assign FWD_E_Reg_Addr = e_q.reg_addr;
  assign FWD_E_Reg_W    = e_q.reg_w;
  assign FWD_E_Reg_Data = e_q.reg_data;
  assign FWD_E_T_new    = e_q.t_new;
  assign E_T_new_next   = sat_dec(e_q.t_new);

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_d_e_reg.sv
// Self-checking bench for d_e_reg: directed hazard scenarios plus randomized traffic
// compared every cycle against a rule-level model of the D/E register.
module tb_d_e_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  D_rs, D_rt, D_Reg_Addr, M_Reg_Addr;
  logic [31:0] D_rs_Data, D_rt_Data, D_Reg_Data, D_PC;
  logic        D_Reg_W, D_valid, M_Reg_W;
  logic [2:0]  D_T_new, D_Tuse_rs, D_Tuse_rt, M_T_new;
  logic [4:0]  E_rs, E_rt, FWD_E_Reg_Addr;
  logic [31:0] E_rs_Data, E_rt_Data, E_PC, FWD_E_Reg_Data;
  logic        E_valid, FWD_E_Reg_W, stall;
  logic [2:0]  FWD_E_T_new, E_T_new_next;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] m_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // model of the E-stage contents
  logic [4:0]  m_rs, m_rt, m_addr;
  logic [31:0] m_rs_data, m_rt_data, m_pc, m_data;
  logic        m_valid, m_w;
  logic [2:0]  m_tnew;
  bit          m_s;

  d_e_reg dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_rs_Data(D_rs_Data), .D_rt_Data(D_rt_Data),
    .D_Reg_Addr(D_Reg_Addr), .D_Reg_W(D_Reg_W), .D_Reg_Data(D_Reg_Data), .D_T_new(D_T_new),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_PC(D_PC), .D_valid(D_valid),
    .M_Reg_Addr(M_Reg_Addr), .M_Reg_W(M_Reg_W), .M_T_new(M_T_new),
    .E_rs(E_rs), .E_rt(E_rt), .E_rs_Data(E_rs_Data), .E_rt_Data(E_rt_Data),
    .E_PC(E_PC), .E_valid(E_valid),
    .FWD_E_Reg_Addr(FWD_E_Reg_Addr), .FWD_E_Reg_W(FWD_E_Reg_W),
    .FWD_E_Reg_Data(FWD_E_Reg_Data), .FWD_E_T_new(FWD_E_T_new),
    .E_T_new_next(E_T_new_next),
`ifdef STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A source hazards if some producer writing it is still more cycles away than D can wait.
  function automatic bit src_late(input logic [4:0] r, input logic [2:0] tuse);
    if (r == 5'd0 || tuse == 3'd7) return 1'b0;
    if (m_w && r == m_addr && int'(tuse) < int'(m_tnew)) return 1'b1;
    if (M_Reg_W && r == M_Reg_Addr && int'(tuse) < int'(M_T_new)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_stall();
    return D_valid && (src_late(D_rs, D_Tuse_rs) || src_late(D_rt, D_Tuse_rt));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      {m_rs, m_rt, m_addr, m_rs_data, m_rt_data, m_pc, m_data, m_valid, m_w, m_tnew} = '0;
`ifdef STALL_CNT_EN
      m_cnt = 0;
`endif
    end else begin
      m_s = model_stall();
`ifdef STALL_CNT_EN
      if (m_s) m_cnt = m_cnt + 1;
`endif
      if (m_s) begin
        {m_rs, m_rt, m_addr, m_rs_data, m_rt_data, m_pc, m_data, m_valid, m_w, m_tnew} = '0;
      end else begin
        m_rs = D_rs; m_rt = D_rt; m_rs_data = D_rs_Data; m_rt_data = D_rt_Data;
        m_pc = D_PC; m_valid = D_valid; m_addr = D_Reg_Addr; m_data = D_Reg_Data;
        m_tnew = D_T_new;
        m_w = D_Reg_W && D_valid && (D_Reg_Addr != 5'd0);
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_E_rs", E_rs, m_rs);
      chk("cyc_E_rt", E_rt, m_rt);
      chk("cyc_E_rs_Data", E_rs_Data, m_rs_data);
      chk("cyc_E_rt_Data", E_rt_Data, m_rt_data);
      chk("cyc_E_PC", E_PC, m_pc);
      chk("cyc_E_valid", E_valid, m_valid);
      chk("cyc_FWD_addr", FWD_E_Reg_Addr, m_addr);
      chk("cyc_FWD_w", FWD_E_Reg_W, m_w);
      chk("cyc_FWD_data", FWD_E_Reg_Data, m_data);
      chk("cyc_FWD_tnew", FWD_E_T_new, m_tnew);
      chk("cyc_tnew_next", E_T_new_next, (m_tnew == 0) ? 32'd0 : 32'(m_tnew) - 32'd1);
      chk("cyc_stall", stall, model_stall());
`ifdef STALL_CNT_EN
      chk("cyc_stall_cnt", stall_cnt, m_cnt);
`endif
    end
  end

  task automatic set_idle();
    D_rs = 0; D_rt = 0; D_rs_Data = 0; D_rt_Data = 0; D_Reg_Addr = 0; D_Reg_W = 0;
    D_Reg_Data = 0; D_T_new = 0; D_Tuse_rs = 3'd7; D_Tuse_rt = 3'd7; D_PC = 0; D_valid = 0;
    M_Reg_Addr = 0; M_Reg_W = 0; M_T_new = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rand_tuse();
    logic [2:0] t;
    t = 3'($urandom_range(0, 3));
    return (t == 3'd3) ? 3'd7 : t;
  endfunction

  task automatic drive_random();
    D_rs = 5'($urandom_range(0, 3));
    D_rt = 5'($urandom_range(0, 3));
    D_rs_Data = $urandom; D_rt_Data = $urandom; D_Reg_Data = $urandom; D_PC = $urandom;
    D_Reg_Addr = 5'($urandom_range(0, 3));
    D_Reg_W = 1'($urandom_range(0, 1));
    D_T_new = 3'($urandom_range(0, 3));
    D_Tuse_rs = rand_tuse();
    D_Tuse_rt = rand_tuse();
    D_valid = ($urandom_range(0, 4) != 0);
    M_Reg_Addr = 5'($urandom_range(0, 3));
    M_Reg_W = 1'($urandom_range(0, 1));
    M_T_new = 3'($urandom_range(0, 2));
  endtask

  initial begin
    set_idle();
    #12;
    chk("rst_E_valid", E_valid, 0);
    chk("rst_E_PC", E_PC, 0);
    chk("rst_FWD_w", FWD_E_Reg_W, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b1;
    cmp_en = 1'b1;
    tick();

    // lw $1 in E, then dependent add in D
    D_valid = 1; D_Reg_Addr = 5'd1; D_Reg_W = 1; D_T_new = 3'd2; D_PC = 32'h3000;
    tick();
    chk("lw_in_E_tnew", FWD_E_T_new, 2);
    chk("lw_tnew_next", E_T_new_next, 1);
    D_rs = 5'd1; D_Tuse_rs = 3'd1; D_Reg_Addr = 5'd2; D_T_new = 3'd1; D_PC = 32'h3004;
    #1;
    chk("lw_use_stall", stall, 1);
    tick();
    chk("bubble_E_valid", E_valid, 0);
    chk("bubble_FWD_w", FWD_E_Reg_W, 0);
    chk("bubble_E_PC", E_PC, 0);

    // M producer against rt
    set_idle();
    D_valid = 1; M_Reg_Addr = 5'd5; M_Reg_W = 1; M_T_new = 3'd1; D_rt = 5'd5; D_Tuse_rt = 3'd0;
    #1;
    chk("m_hazard_stall", stall, 1);
    D_Tuse_rt = 3'd1;
    #1;
    chk("m_ok_nostall", stall, 0);

    // jal: result known in D
    set_idle();
    D_valid = 1; D_Reg_Addr = 5'd31; D_Reg_W = 1; D_Reg_Data = 32'h3008; D_T_new = 3'd0;
    tick();
    chk("jal_addr", FWD_E_Reg_Addr, 31);
    chk("jal_data", FWD_E_Reg_Data, 32'h3008);
    chk("jal_tnew", FWD_E_T_new, 0);
    chk("jal_tnew_next", E_T_new_next, 0);
    chk("jal_w", FWD_E_Reg_W, 1);

    // writes to $0 never forward and never stall
    set_idle();
    D_valid = 1; D_Reg_Addr = 5'd0; D_Reg_W = 1; D_T_new = 3'd2;
    tick();
    chk("zero_w", FWD_E_Reg_W, 0);
    D_rs = 5'd0; D_Tuse_rs = 3'd0; M_Reg_Addr = 5'd0; M_Reg_W = 1; M_T_new = 3'd3;
    #1;
    chk("zero_nostall", stall, 0);

    // async reset mid-cycle
    set_idle();
    D_valid = 1; D_PC = 32'h3004;
    tick();
    chk("pre_rst_PC", E_PC, 32'h3004);
    #2;
    reset = 1'b0;
    D_valid = 0;
    #1;
    chk("async_rst_PC", E_PC, 0);
    chk("async_rst_valid", E_valid, 0);
    chk("async_rst_stall", stall, 0);
    tick();
    reset = 1'b1;
    D_valid = 1; D_PC = 32'h3004;
    tick();
    chk("post_rst_capture", E_PC, 32'h3004);

`ifdef STALL_CNT_EN
    set_idle();
    D_valid = 1; M_Reg_Addr = 5'd5; M_Reg_W = 1; M_T_new = 3'd3; D_rt = 5'd5; D_Tuse_rt = 3'd0;
    repeat (3) tick();
    set_idle();
    #1;
    chk("stall_cnt_3", stall_cnt, 3);
`endif

    for (int i = 0; i < 2000; i++) begin
      drive_random();
      tick();
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
